sipo_deserializer: RTL

Parametrised serial-in/parallel-out deserializer with word framing and a valid/ready output buffer. It sits behind the UART receive bit-sampler: it accepts one data bit per `shift_en` strobe, assembles `WIDTH`-bit words in LSB-first or MSB-first order, and presents each completed word on a one-deep holding register. Downstream logic (FIFO, register file) consumes the word with a valid/ready handshake. Words that arrive while the buffer is still occupied are dropped and flagged.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sipo_hold_reg.sv | 82 ++++++++
 rtl/sipo_deserializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_WORD_W_DEFAULT : default data word length in bits
//   cnt_width(n)        : width of a counter that counts 0..n-1, never < 1
//   sipo_state_e        : deserializer FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_WORD_W_DEFAULT = 8;

    // max(1, $clog2(n)): a one-bit counter is still needed when n <= 2.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,   // no bits of the current word received yet
        SHIFT = 1'b1    // 1..WIDTH-1 bits received
    } sipo_state_e;

endpackage

// File: rtl/sipo_hold_reg.sv
// ---------------------------------------------------------------------------
// sipo_hold_reg
// One-deep valid/ready holding register for completed deserializer words.
// A new word is accepted when the register is empty or is being consumed in
// the same cycle; otherwise it is dropped and a one-cycle overrun pulse is
// raised.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   load       in   a completed word is offered this cycle
//   load_data  in   WIDTH  the completed word
//   out_ready  in   consumer accepts out_data when out_valid && out_ready
//   out_data   out  WIDTH  held word
//   out_valid  out  register occupied
//   overrun    out  one-cycle pulse after an offered word was dropped
// ---------------------------------------------------------------------------
module sipo_hold_reg
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WORD_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             valid_reg;
    logic             valid_next;
    logic             overrun_reg;
    logic             overrun_next;

    logic consume;
    logic accept;

    // A word being consumed frees the slot in the same cycle, so a completion
    // that coincides with a consume is accepted and out_valid never dips.
    assign consume = valid_reg && out_ready;
    assign accept  = load && (!valid_reg || out_ready);

    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = 1'b0;

        if (accept) begin
            data_next  = load_data;
            valid_next = 1'b1;
        end else if (consume) begin
            // out_data deliberately keeps its last value after a consume.
            valid_next = 1'b0;
        end

        if (load && !accept) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
// Serial-in/parallel-out deserializer with word framing. One bit is taken per
// shift_en strobe; every WIDTH bits form a word that is handed to a one-deep
// valid/ready holding register (sipo_hold_reg).
//
// Parameters:
//   WIDTH      word length, 2..32
//   LSB_FIRST  1: first bit lands in out_data[0]; 0: in out_data[WIDTH-1]
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous abort of the word in progress
//   shift_en   in   qualifies serial_in for one bit
//   serial_in  in   serial data bit
//   out_data   out  WIDTH  completed word in the holding register
//   out_valid  out  holding register occupied
//   out_ready  in   consumer handshake
//   busy       out  a word is partially assembled
//   bit_count  out  CNT_W  bits received in the current word
//   overrun    out  one-cycle pulse when a completed word was dropped
// ---------------------------------------------------------------------------
module sipo_deserializer
    import uart_pkg::*;
#(
    parameter  int WIDTH     = UART_WORD_W_DEFAULT,
    parameter  int LSB_FIRST = 1,
    localparam int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    // The shift register only ever holds WIDTH-1 bits: the WIDTH-th bit is
    // taken straight from serial_in and the full word goes to the hold reg.
    sipo_state_e      state_reg;
    sipo_state_e      state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-2:0] shreg_reg;
    logic [WIDTH-2:0] shreg_next;

    logic [WIDTH-1:0] word_shift;   // shift register after taking serial_in
    logic [WIDTH-2:0] shreg_keep;   // the part of word_shift that stays
    logic             last_bit;
    logic             word_done;

    // -----------------------------------------------------------------------
    // Bit ordering
    // LSB first: shift right, new bit enters at the top; after WIDTH bits
    // the first bit has reached bit 0. MSB first: shift left, new bit at 0.
    // -----------------------------------------------------------------------
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign word_shift[WIDTH-1] = serial_in;
            for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
                assign word_shift[gi] = shreg_reg[gi];
            end
            assign shreg_keep = word_shift[WIDTH-1:1];
        end else begin : g_msb_first
            assign word_shift[0] = serial_in;
            for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
                assign word_shift[gi] = shreg_reg[gi-1];
            end
            assign shreg_keep = word_shift[WIDTH-2:0];
        end
    endgenerate

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // FSM next-state, counter and shift register
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        word_done  = 1'b0;

        if (clear) begin
            // clear wins over a coincident shift_en; that bit is lost.
            state_next = IDLE;
            cnt_next   = '0;
            shreg_next = '0;
        end else if (shift_en) begin
            shreg_next = shreg_keep;
            case (state_reg)
                IDLE: begin
                    // WIDTH >= 2, so the first bit never completes a word.
                    state_next = SHIFT;
                    cnt_next   = CNT_W'(1);
                end
                SHIFT: begin
                    if (last_bit) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        word_done  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shreg_reg <= shreg_next;
        end
    end

    assign busy      = (state_reg == SHIFT);
    assign bit_count = cnt_reg;

    // -----------------------------------------------------------------------
    // Output holding register
    // -----------------------------------------------------------------------
    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (word_done),
        .load_data (word_shift),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule
